axi_wd_order_mux: RTL and testbench

AXI_WD_ORDER_MUX -- requirements
Module: axi_wd_order_mux

---
 rtl/axi_wd_order_mux.sv | 195 +++++++++++++++++++
 tb/tb_axi_wd_order_mux.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wd_order_mux.sv
// ---------------------------------------------------------------------------
// axi_wd_order_mux
//
// Routes AXI write-data beats from NUM_M masters onto one slave W channel.
// The W owner order follows the order in which AW handshakes were completed
// toward the slave. A small FIFO of master indices records that order. The
// head entry owns the W channel until its burst's last beat is accepted.
// Beats pass through a 2-entry skid slice, so every s_w* output is
// registered and the channel can still move one beat per cycle.
//
// Ports
//   ACLK, ARESETN        clock, synchronous active-low reset
//   aw_push, aw_idx      AW handshake completed this cycle, and its master index
//   order_full           order queue full (upstream must not push)
//   order_count          number of queued write bursts
//   push_err             sticky flag: a push was dropped (queue full or bad index)
//   m_wdata/m_wstrb/
//   m_wlast/m_wvalid     per-master W channels; master i uses slice i
//   m_wready             per-master W ready; only the head master can see 1
//   s_wdata/s_wstrb/
//   s_wlast/s_wvalid     registered W channel toward the slave
//   s_wready             slave W ready
// ---------------------------------------------------------------------------
module axi_wd_order_mux #(
  parameter int NUM_M       = 2,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int ORDER_DEPTH = 4,
  parameter int IDX_W       = ($clog2(NUM_M) > 1) ? $clog2(NUM_M) : 1,
  parameter int CNT_W       = $clog2(ORDER_DEPTH) + 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     aw_push,
  input  logic [IDX_W-1:0]         aw_idx,
  output logic                     order_full,
  output logic [CNT_W-1:0]         order_count,
  output logic                     push_err,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  input  logic [NUM_M*STRB_W-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]         m_wlast,
  input  logic [NUM_M-1:0]         m_wvalid,
  output logic [NUM_M-1:0]         m_wready,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic                     s_wlast,
  output logic                     s_wvalid,
  input  logic                     s_wready
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam logic [IDX_W:0] NUM_M_V = NUM_M[IDX_W:0];

  // -------------------------------------------------------------------------
  // AW-order queue
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] order_mem [ORDER_DEPTH];
  // The pointers carry one extra wrap bit, so full and empty differ and the
  // count is just their difference.
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             order_empty;
  logic [IDX_W-1:0] head;
  logic             idx_ok;
  logic             push_ok;
  logic             pop;

  assign order_count = wr_ptr - rd_ptr;
  assign order_full  = (order_count == CNT_W'(ORDER_DEPTH));
  assign order_empty = (order_count == '0);
  assign head        = order_mem[rd_ptr[PTR_W-1:0]];
  assign idx_ok      = ({1'b0, aw_idx} < NUM_M_V);

  // -------------------------------------------------------------------------
  // Head master selection
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] sel_data;
  logic [STRB_W-1:0] sel_strb;
  logic              sel_last;
  logic              sel_valid;

  always_comb begin
    sel_data  = '0;
    sel_strb  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (head == IDX_W'(i)) begin
        sel_data  = m_wdata[i*DATA_W +: DATA_W];
        sel_strb  = m_wstrb[i*STRB_W +: STRB_W];
        sel_last  = m_wlast[i];
        sel_valid = m_wvalid[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Skid slice state
  // -------------------------------------------------------------------------
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [STRB_W-1:0] skid_strb;
  logic              skid_last;
  logic              slice_ready;
  logic              beat_take;
  logic              main_free;

  // The slice takes a beat whenever the skid entry is empty. If the main
  // register stalls, that beat goes into the skid entry.
  assign slice_ready = ~skid_valid;
  assign beat_take   = ARESETN & ~order_empty & slice_ready & sel_valid;
  assign pop         = beat_take & sel_last;
  // A push into a full queue is legal only when the same edge pops the head.
  assign push_ok     = aw_push & idx_ok & (~order_full | pop);
  assign main_free   = ~s_wvalid | s_wready;

  // Ready goes only to the head master. Valid from other masters has no
  // effect.
  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_ready
      assign m_wready[gi] = ARESETN & ~order_empty & slice_ready &
                            (head == IDX_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Queue pointers and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      push_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
      if (aw_push && !push_ok) begin
        push_err <= 1'b1;
      end
    end
  end

  // Queue storage is not reset: an entry is readable only after its push has
  // advanced wr_ptr.
  always_ff @(posedge ACLK) begin
    if (ARESETN && push_ok) begin
      order_mem[wr_ptr[PTR_W-1:0]] <= aw_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Output slice: main register drives s_w*, skid register catches one beat
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s_wvalid   <= 1'b0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      s_wlast    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_strb  <= '0;
      skid_last  <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // The held beat is older than anything new. No new beat can arrive
        // this cycle, because ready was low.
        s_wvalid   <= 1'b1;
        s_wdata    <= skid_data;
        s_wstrb    <= skid_strb;
        s_wlast    <= skid_last;
        skid_valid <= 1'b0;
      end else if (beat_take) begin
        s_wvalid <= 1'b1;
        s_wdata  <= sel_data;
        s_wstrb  <= sel_strb;
        s_wlast  <= sel_last;
      end else begin
        s_wvalid <= 1'b0;
      end
    end else if (beat_take) begin
      // The main register is stalled, so its contents stay unchanged. Keep
      // the incoming beat in the skid register.
      skid_valid <= 1'b1;
      skid_data  <= sel_data;
      skid_strb  <= sel_strb;
      skid_last  <= sel_last;
    end
  end

endmodule

// File: tb/tb_axi_wd_order_mux.sv
// ---------------------------------------------------------------------------
// tb_axi_wd_order_mux
//
// Directed scoreboard bench. Each stimulus step queues master beats and
// pushes the expected output beats, in burst order, into exp_q. A separate
// monitor on the falling edge pops exp_q and compares it against every beat
// the slave accepts. The monitor also checks that s_w* hold steady during
// stalls. The main sequence checks control flags and latencies directly.
// ---------------------------------------------------------------------------
module tb_axi_wd_order_mux;

  localparam int NUM_M = 3;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int CW    = 3;

  typedef struct packed {
    logic [SW-1:0] strb;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic                  ACLK = 1'b0;
  logic                  ARESETN = 1'b0;
  logic                  aw_push = 1'b0;
  logic [IW-1:0]         aw_idx = '0;
  logic                  order_full;
  logic [CW-1:0]         order_count;
  logic                  push_err;
  logic [NUM_M*DW-1:0]   m_wdata = '0;
  logic [NUM_M*SW-1:0]   m_wstrb = '0;
  logic [NUM_M-1:0]      m_wlast = '0;
  logic [NUM_M-1:0]      m_wvalid = '0;
  logic [NUM_M-1:0]      m_wready;
  logic [DW-1:0]         s_wdata;
  logic [SW-1:0]         s_wstrb;
  logic                  s_wlast;
  logic                  s_wvalid;
  logic                  s_wready = 1'b1;

  axi_wd_order_mux #(
    .NUM_M(NUM_M), .DATA_W(DW), .STRB_W(SW), .ORDER_DEPTH(DEPTH),
    .IDX_W(IW), .CNT_W(CW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .aw_push(aw_push), .aw_idx(aw_idx),
    .order_full(order_full), .order_count(order_count), .push_err(push_err),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready)
  );

  always #5 ACLK = ~ACLK;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc_cnt  = 0;
  beat_t mq0[$];
  beat_t mq1[$];
  beat_t mq2[$];
  beat_t exp_q[$];
  int    beat_cyc[$];

  always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Queue an n-beat burst on master m and record the beats the slave should see.
  task automatic load(input int m, input logic [31:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 32'(k);
      b.strb = 4'hF ^ 4'(k);
      b.last = (k == n - 1);
      case (m)
        0:       mq0.push_back(b);
        1:       mq1.push_back(b);
        default: mq2.push_back(b);
      endcase
      exp_q.push_back(b);
    end
  endtask

  function automatic beat_t front(input int m);
    beat_t b;
    b = '0;
    case (m)
      0:       if (mq0.size() > 0) b = mq0[0];
      1:       if (mq1.size() > 0) b = mq1[0];
      default: if (mq2.size() > 0) b = mq2[0];
    endcase
    return b;
  endfunction

  function automatic bit has_beat(input int m);
    case (m)
      0:       return mq0.size() > 0;
      1:       return mq1.size() > 0;
      default: return mq2.size() > 0;
    endcase
  endfunction

  // Master models: a beat counts as taken when valid and ready are both high
  // at the edge. After the edge, the next queued beat is presented.
  logic [NUM_M-1:0] fire_s = '0;
  beat_t            drv_b;
  always @(negedge ACLK) fire_s <= m_wvalid & m_wready;
  always @(posedge ACLK) begin
    #2;
    if (fire_s[0] && mq0.size() > 0) void'(mq0.pop_front());
    if (fire_s[1] && mq1.size() > 0) void'(mq1.pop_front());
    if (fire_s[2] && mq2.size() > 0) void'(mq2.pop_front());
    for (int i = 0; i < NUM_M; i++) begin
      drv_b = front(i);
      m_wvalid[i]          = has_beat(i);
      m_wdata[i*DW +: DW]  = drv_b.data;
      m_wstrb[i*SW +: SW]  = drv_b.strb;
      m_wlast[i]           = drv_b.last;
    end
  end

  // Output monitor / scoreboard
  logic        stalled = 1'b0;
  logic [36:0] held = '0;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) check("hold_stable", {s_wstrb, s_wlast, s_wdata}, held);
      if (s_wvalid && s_wready) begin
        $display("beat data=0x%08h strb=0x%0h last=%0d cyc=%0d", s_wdata, s_wstrb, s_wlast, cyc_cnt);
        check("beat_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("s_wdata", s_wdata, exp_q[0].data);
          check("s_wstrb", s_wstrb, exp_q[0].strb);
          check("s_wlast", s_wlast, exp_q[0].last);
          void'(exp_q.pop_front());
          beat_cyc.push_back(cyc_cnt);
        end
      end
      stalled <= s_wvalid && !s_wready;
      held    <= {s_wstrb, s_wlast, s_wdata};
    end
  end

  task automatic wait_drain(input int n);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < n) begin
      cyc();
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    aw_push = 1'b0;
    mq0.delete(); mq1.delete(); mq2.delete(); exp_q.delete();
    cyc();
    ARESETN = 1'b1;
  endtask

  task automatic push_one(input logic [IW-1:0] idx);
    aw_push = 1'b1;
    aw_idx  = idx;
    cyc();
    aw_push = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    // Reset state
    repeat (3) cyc();
    check("rst_count", order_count, 0);
    check("rst_full", order_full, 0);
    check("rst_err", push_err, 0);
    check("rst_svalid", s_wvalid, 0);
    check("rst_mready", m_wready, 0);
    check("rst_sdata", s_wdata, 0);
    ARESETN = 1'b1;
    cyc();

    // Order: idx 1 then idx 0; M0 offers its beats while M1 owns the channel.
    $display("test order");
    beat_cyc.delete();
    load(1, 32'hA1, 2);
    load(0, 32'hB1, 2);
    aw_push = 1'b1; aw_idx = 2'd1;
    cyc();
    aw_idx = 2'd0;
    cyc();
    aw_push = 1'b0;
    wait_drain(50);
    check("order_nbeats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4)
      for (int k = 1; k < 4; k++) check("order_gap", beat_cyc[k] - beat_cyc[k-1], 1);
    check("order_count_end", order_count, 0);

    // Backpressure: 4-beat burst, ready pattern applied once beats are in the slice.
    $display("test backpressure");
    load(2, 32'hC0, 4);
    push_one(2'd2);
    cyc();
    for (int k = 0; k < 7; k++) begin
      s_wready = pat[k][0];
      cyc();
    end
    s_wready = 1'b1;
    wait_drain(20);

    // Full queue, push+pop while full, then an illegal fifth push.
    $display("test full");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_one(2'd2);
      check("full_count", order_count, 32'(k + 1));
      check("full_flag", order_full, (k == 3));
    end
    load(2, 32'hD0, 1);
    aw_push = 1'b1; aw_idx = 2'd2;
    cyc();
    check("pushpop_count", order_count, 4);
    check("pushpop_full", order_full, 1);
    check("pushpop_err", push_err, 0);
    cyc();
    aw_push = 1'b0;
    check("overflow_count", order_count, 4);
    check("overflow_err", push_err, 1);
    for (int k = 0; k < 4; k++) load(2, 32'hE0 + 32'(k), 1);
    wait_drain(40);
    check("full_drained", order_count, 0);
    check("err_sticky", push_err, 1);

    // Bad index on a 3-master instance
    $display("test bad index");
    do_reset();
    check("badidx_pre_err", push_err, 0);
    push_one(2'd3);
    check("badidx_count", order_count, 0);
    check("badidx_err", push_err, 1);
    push_one(2'd1);
    check("after_bad_count", order_count, 1);

    // Empty-queue latency
    $display("test latency");
    do_reset();
    s_wready = 1'b1;
    load(0, 32'h50, 1);
    aw_push = 1'b1; aw_idx = 2'd0;
    @(negedge ACLK);
    check("lat_mready_t", m_wready[0], 0);
    @(posedge ACLK); #1;
    aw_push = 1'b0;
    @(negedge ACLK);
    check("lat_mready_t1", m_wready[0], 1);
    check("lat_svalid_t1", s_wvalid, 0);
    @(negedge ACLK);
    check("lat_svalid_t2", s_wvalid, 1);
    cyc();
    wait_drain(10);

    // Reset mid-burst with three queued bursts and the skid entry occupied
    $display("test reset mid-burst");
    do_reset();
    push_one(2'd3);
    s_wready = 1'b0;
    load(0, 32'h60, 3);
    load(1, 32'h70, 2);
    load(2, 32'h80, 2);
    aw_push = 1'b1; aw_idx = 2'd0;
    cyc();
    aw_idx = 2'd1;
    cyc();
    aw_idx = 2'd2;
    cyc();
    aw_push = 1'b0;
    repeat (2) cyc();
    check("mid_count", order_count, 3);
    check("mid_svalid", s_wvalid, 1);
    check("mid_sdata", s_wdata, 32'h60);
    check("mid_mready", m_wready, 0);
    check("mid_err", push_err, 1);
    ARESETN = 1'b0;
    aw_push = 1'b1; aw_idx = 2'd1;
    mq0.delete(); mq1.delete(); mq2.delete(); exp_q.delete();
    cyc();
    ARESETN = 1'b1;
    aw_push = 1'b0;
    check("rst2_count", order_count, 0);
    check("rst2_full", order_full, 0);
    check("rst2_err", push_err, 0);
    check("rst2_svalid", s_wvalid, 0);
    check("rst2_sdata", s_wdata, 0);
    check("rst2_sstrb", s_wstrb, 0);
    check("rst2_slast", s_wlast, 0);
    check("rst2_mready", m_wready, 0);
    @(negedge ACLK);
    check("rst2_svalid_after", s_wvalid, 0);
    s_wready = 1'b1;
    cyc();
    cyc();
    check("final_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
